// File: rtl/cascade_iir_low_pass_filter.sv
`default_nettype none
// ============================================================================
// Module      : cascade_iir_low_pass_filter
// Description : NUM_STAGES cascaded first-order IIR low-pass stages,
//               y += (x - y) >>> k, sharing one time-multiplexed datapath.
//               Each stage has its own runtime shift and bypass. Valid/ready
//               input handshake, sticky drop flag and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_iir_low_pass_filter #(
  parameter int DATA_W     = 16,
  parameter int NUM_STAGES = 8,
  parameter int SHIFT_W    = 4,
  // Guard bits must cover the largest shift (2^SHIFT_W - 1) so that a
  // maximal shift still moves the accumulator by a representable amount.
  parameter int FRAC_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [NUM_STAGES-1:0]         stage_enable,
  input  logic [NUM_STAGES*SHIFT_W-1:0] stage_shift,
  input  logic signed [DATA_W-1:0]      sample_in,
  input  logic                          sample_in_valid,
  output logic                          sample_in_ready,
  output logic signed [DATA_W-1:0]      sample_out,
  output logic                          sample_out_valid,
  output logic                          sample_dropped
);

  localparam int ACC_W = DATA_W + FRAC_W;
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  // Running input of the stage being processed: the accepted sample for
  // stage 0, then the freshly updated accumulator of the previous stage.
  logic signed [ACC_W-1:0] x_reg;
  logic signed [ACC_W-1:0] acc [NUM_STAGES];
  logic [SHIFT_W-1:0]      shift_field [NUM_STAGES];

  logic signed [ACC_W-1:0] cur_acc;
  logic                    cur_enable;
  logic [SHIFT_W-1:0]      cur_shift;
  logic signed [ACC_W:0]   diff;
  logic signed [ACC_W:0]   step;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] next_acc;

  generate
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_shift_unpack
      assign shift_field[g] = stage_shift[g*SHIFT_W +: SHIFT_W];
    end
  endgenerate

  assign sample_in_ready = (state == IDLE);

  // Shared stage arithmetic: select stage idx, compute its next accumulator.
  always_comb begin
    cur_acc    = acc[idx];
    cur_enable = stage_enable[idx];
    cur_shift  = shift_field[idx];
    // One extra bit so x - acc cannot wrap; the sum is a convex combination
    // of acc and x, so truncating back to ACC_W bits is lossless.
    diff       = {x_reg[ACC_W-1], x_reg} - {cur_acc[ACC_W-1], cur_acc};
    step       = diff >>> cur_shift;
    sum        = {cur_acc[ACC_W-1], cur_acc} + step;
    // A bypassed stage tracks its input so re-enabling it does not glitch.
    next_acc   = cur_enable ? ACC_W'(sum) : x_reg;
  end

  // Sequencer, stage accumulators, output and drop-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      idx              <= '0;
      x_reg            <= '0;
      for (int i = 0; i < NUM_STAGES; i++) acc[i] <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      sample_dropped   <= 1'b0;
    end else if (clear) begin
      // Abort any run silently; sample_out keeps its last value.
      state            <= IDLE;
      idx              <= '0;
      for (int i = 0; i < NUM_STAGES; i++) acc[i] <= '0;
      sample_out_valid <= 1'b0;
      sample_dropped   <= 1'b0;
    end else begin
      sample_out_valid <= 1'b0;
      if (sample_in_valid && !sample_in_ready) begin
        sample_dropped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sample_in_valid) begin
            x_reg <= {sample_in, {FRAC_W{1'b0}}};
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc[idx] <= next_acc;
          x_reg    <= next_acc;
          if (idx == LAST_IDX) begin
            // Dropping the fraction bits is an arithmetic shift (floor).
            sample_out       <= next_acc[ACC_W-1:FRAC_W];
            sample_out_valid <= 1'b1;
            idx              <= '0;
            state            <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cascade_iir_low_pass_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cascade_iir_low_pass_filter
// Description : Scoreboard bench for cascade_iir_low_pass_filter (4 stages).
//               Directed vectors with hand-computed expected outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cascade_iir_low_pass_filter;

  localparam int NS = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   clear = 1'b0;
  logic [NS-1:0]          stage_enable;
  logic [NS*4-1:0]        stage_shift;
  logic signed [15:0]     sample_in;
  logic                   sample_in_valid;
  logic                   sample_in_ready;
  logic signed [15:0]     sample_out;
  logic                   sample_out_valid;
  logic                   sample_dropped;

  typedef struct {
    logic signed [15:0] val;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  cascade_iir_low_pass_filter #(
    .DATA_W    (16),
    .NUM_STAGES(NS),
    .SHIFT_W   (4),
    .FRAC_W    (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .stage_enable    (stage_enable),
    .stage_shift     (stage_shift),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .sample_in_ready (sample_in_ready),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .sample_dropped  (sample_dropped)
  );

  always #5 clk = ~clk;

  // Edge counter used to check output latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && sample_out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: out=%0d, required no pulse", sample_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (sample_out !== mon_e.val || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL output: out=%0d at cycle %0d, required %0d at cycle %0d",
                   sample_out, cyc, mon_e.val, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Wait for ready, present one sample for one edge, queue its expected output.
  task automatic send(input logic signed [15:0] v, input logic signed [15:0] exp_v);
    int n = 0;
    while (!sample_in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", sample_in_ready, 1);
    sample_in       = v;
    sample_in_valid = 1'b1;
    tick();
    exp_q.push_back('{exp_v, cyc + NS});
    sample_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    check("rst_out", sample_out, 0);
    check("rst_valid", sample_out_valid, 0);
    check("rst_dropped", sample_dropped, 0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    stage_enable    = '0;
    stage_shift     = '0;
    sample_in       = '0;
    sample_in_valid = 1'b0;
    #2;
    check("reset_out", sample_out, 0);
    check("reset_valid", sample_out_valid, 0);
    check("reset_dropped", sample_dropped, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("ready_after_reset", sample_in_ready, 1);

    // Two active stages with k=1, remaining stages bypassed.
    stage_enable = 4'b0011;
    stage_shift  = 16'h0011;
    send(16'sd1000, 16'sd250);  drain();
    send(16'sd1000, 16'sd500);  drain();
    send(16'sd1000, 16'sd687);  drain();

    // Negative input and flooring.
    reset_pulse();
    send(-16'sd1000, -16'sd250); drain();
    reset_pulse();
    send(16'sd1, 16'sd0);        drain();
    reset_pulse();
    send(16'sd2, 16'sd0);        drain();
    send(16'sd0, 16'sd0);        drain();

    // Full bypass, then glitch-free re-enable of stage 0 with k=15.
    reset_pulse();
    stage_enable = 4'b0000;
    send(16'sd1234, 16'sd1234);  drain();
    send(-16'sd5, -16'sd5);      drain();
    stage_enable = 4'b0001;
    stage_shift  = 16'h000F;
    send(16'sd0, -16'sd5);       drain();

    // Continuous valid: one accept every NS+1 cycles, sticky drop flag.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    stage_enable    = 4'b1111;
    stage_shift     = 16'h1111;
    sample_in       = 16'sd0;
    sample_in_valid = 1'b1;
    for (int j = 0; j < 15; j++) begin
      check("hold_ready", sample_in_ready, (j % 5 == 0) ? 1 : 0);
      check("hold_dropped", sample_dropped, (j >= 2) ? 1 : 0);
      if (j % 5 == 0) exp_q.push_back('{16'sd0, cyc + 1 + NS});
      if (j == 14) sample_in_valid = 1'b0;
      tick();
    end
    drain();
    check("dropped_sticky", sample_dropped, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_dropped", sample_dropped, 0);

    // Clear aborting a run: no pulse, output held, accumulators zeroed.
    send(16'sd1000, 16'sd62);    drain();
    sample_in       = 16'sd500;
    sample_in_valid = 1'b1;
    tick();
    sample_in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ready", sample_in_ready, 1);
    check("clear_holds_out", sample_out, 62);
    repeat (8) tick();
    send(16'sd1000, 16'sd62);    drain();

    // Asynchronous reset in the middle of a run.
    sample_in       = 16'sd1000;
    sample_in_valid = 1'b1;
    tick();
    sample_in_valid = 1'b0;
    tick();
    reset_pulse();
    repeat (8) tick();
    send(16'sd1000, 16'sd62);    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
